conv_window_gen: RTL



---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_window_gen_line_buf.sv | 28 ++
 rtl/conv_window_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and patch packing helper for the conv window generator.
package conv_pkg;

    localparam int K         = 3;
    localparam int DW        = 8;
    localparam int CH        = 3;
    localparam int WIN_BYTES = K * K * CH;
    localparam int WIN_W     = WIN_BYTES * DW;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // MSB of element e; elements are packed from the top of the word down
    function automatic int elem_msb(input int e, input int dw, input int ch);
        return 9 * ch * dw - 1 - dw * e;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buf.sv
// Two line buffers sharing a column index; mid row shifts into top row on each write.
module conv_line_buf #(
    parameter int IMG_W = 16,
    parameter int PW    = 24,
    parameter int CW    = 4
) (
    input  logic          clk_i,
    input  logic [CW-1:0] col_i,
    input  logic          we_i,
    input  logic [PW-1:0] pix_i,
    output logic [PW-1:0] top_o,
    output logic [PW-1:0] mid_o
);

    logic [PW-1:0] top_q [IMG_W];
    logic [PW-1:0] mid_q [IMG_W];

    assign top_o = top_q[col_i];
    assign mid_o = mid_q[col_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            top_q[col_i] <= mid_q[col_i];
            mid_q[col_i] <= pix_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3xCH patch generator (valid positions only, no padding).
// Optional stall counter port enabled by CONV_WIN_STALL_CNT_EN.
module conv_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int DW    = 8,
    parameter int CH    = 3
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [CH*DW-1:0]  pix_data_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    output logic [9*CH*DW-1:0] win_data_o,
    output logic              win_valid_o,
    input  logic              win_ready_i,
`ifdef CONV_WIN_STALL_CNT_EN
    output logic              frame_done_o,
    output logic [15:0]       stall_cnt_o
`else
    output logic              frame_done_o
`endif
);

    import conv_pkg::*;

    localparam int PW = CH * DW;
    localparam int WW = 9 * CH * DW;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_e        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          rdy_q;
    logic          win_valid_q;
    logic [WW-1:0] win_data_q;
    logic          done_q;

    logic [2:0][2:0][PW-1:0] wc_q;
    logic [2:0][2:0][PW-1:0] wn;
    logic [WW-1:0] pack;
    logic [PW-1:0] top, mid;
    logic          pix_fire, new_patch, last_col, last_row, out_hs;

    conv_line_buf #(
        .IMG_W (IMG_W),
        .PW    (PW),
        .CW    (CW)
    ) u_lb (
        .clk_i (clk_i),
        .col_i (col_q),
        .we_i  (pix_fire),
        .pix_i (pix_data_i),
        .top_o (top),
        .mid_o (mid)
    );

    assign pix_ready_o  = rdy_q && (state_q != ST_DONE)
                       && (!win_valid_q || win_ready_i);
    assign pix_fire     = pix_valid_i && pix_ready_o;
    assign last_col     = (col_q == CW'(IMG_W - 1));
    assign last_row     = (row_q == RW'(IMG_H - 1));
    assign new_patch    = pix_fire && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign out_hs       = win_valid_q && win_ready_i;
    assign win_valid_o  = win_valid_q;
    assign win_data_o   = win_data_q;
    assign frame_done_o = done_q;

    // wn[c][r]: column 0 is leftmost, row 0 is top
    always_comb begin
        wn       = '0;
        wn[0]    = wc_q[1];
        wn[1]    = wc_q[2];
        wn[2][0] = top;
        wn[2][1] = mid;
        wn[2][2] = pix_data_i;
    end

    always_comb begin
        pack = '0;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    pack[elem_msb(ch*9 + r*3 + c, DW, CH) -: DW] =
                        wn[c][r][PW-1-ch*DW -: DW];
    end

    always_ff @(posedge clk_i) begin
        if (pix_fire) wc_q <= wn;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            col_q       <= '0;
            row_q       <= '0;
            rdy_q       <= 1'b0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            rdy_q  <= 1'b1;
            done_q <= 1'b0;
            if (new_patch) begin
                win_valid_q <= 1'b1;
                win_data_q  <= pack;
            end else if (win_ready_i) begin
                win_valid_q <= 1'b0;
            end
            if (pix_fire) begin
                col_q <= last_col ? '0 : col_q + 1'b1;
                if (last_col) row_q <= last_row ? '0 : row_q + 1'b1;
            end
            unique case (state_q)
                ST_FILL: if (pix_fire && last_col && row_q == RW'(1)) state_q <= ST_RUN;
                ST_RUN:  if (pix_fire && last_col && last_row) state_q <= ST_DONE;
                ST_DONE: if (out_hs) begin
                    done_q  <= 1'b1;
                    row_q   <= '0;
                    col_q   <= '0;
                    state_q <= ST_FILL;
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

`ifdef CONV_WIN_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (done_q) begin
            stall_q <= '0;
        end else if (win_valid_q && !win_ready_i && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule
